mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates one single-ported unified memory bus between two requesters.
- Requester 1: I-cache line refill, a burst of ARB_LINE_WORDS word reads.
- Requester 2: MEM-stage load/store unit, single-word read or write.
- Sits between the pipeline's cache/LSU and the memory model. Sequences refill bursts and applies data-priority arbitration with an I-side anti-starvation counter.

Parameters:
XLEN, 32, data/address width
LINE_WORDS, 4, words per I-cache line (ICACHE_LINE_SIZE/4)
STARVE_LIMIT, 4, consecutive data grants while I-side waits before I-side is forced to win

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
ic_req_valid  in  1  refill request
ic_req_addr  in  XLEN  byte address of missing word
ic_req_ready  out  1  refill accepted (1-cycle pulse)
ic_rdata_valid  out  1  refill word valid
ic_rdata  out  XLEN  refill word
ic_rdata_idx  out  $clog2(LINE_WORDS)  word index within line
ic_rdata_last  out  1  final word of burst
d_req_valid  in  1  data request
d_req_we  in  1  1=store
d_req_addr  in  XLEN  word-aligned address
d_req_wdata  in  XLEN  store data
d_req_be  in  XLEN/8  byte enables
d_req_ready  out  1  data request accepted (pulse)
d_rsp_valid  out  1  data response/ack
d_rsp_rdata  out  XLEN  load data
mem_req_valid  out  1  bus request
mem_req_ready  in  1  bus accepts
mem_req_we  out  1  write
mem_req_addr  out  XLEN  word address
mem_req_wdata  out  XLEN  write data
mem_req_be  out  XLEN/8  byte enables
mem_rsp_valid  in  1  response (one per accepted request, in order, ≥1 cycle later)
mem_rsp_rdata  in  XLEN  read data
busy  out  1  state != IDLE

Behaviour:
- Clock is clk. Reset rst is asynchronous and active-high.
- On reset: state IDLE, word/starve counters 0, every output 0.
- One outstanding bus transaction at a time.
- States: IDLE, D_REQ, D_WAIT, IC_REQ, IC_WAIT.
- IDLE arbitration (one winner per cycle):
  - Data wins if d_req_valid, unless ic_req_valid && starve_cnt==STARVE_LIMIT.
  - Winner's ready pulses in that cycle; its request fields are registered.
  - Next state is D_REQ or IC_REQ.
- D_REQ: mem_req_valid=1 with registered fields; hold until mem_req_ready, then D_WAIT.
- D_WAIT: on mem_rsp_valid, d_rsp_valid=1 and d_rsp_rdata=mem_rsp_rdata (combinational pass-through), then IDLE. Stores also receive the ack.
- IC_REQ: mem_req_valid=1, we=0, be=all ones, addr={line_base, word_ptr, 2'b00}. On mem_req_ready go to IC_WAIT.
- IC_WAIT: on mem_rsp_valid, ic_rdata_valid=1, ic_rdata_idx=word_ptr, ic_rdata_last=(beat_cnt==LINE_WORDS-1).
  - If not last: word_ptr wraps modulo LINE_WORDS, beat_cnt++, back to IC_REQ.
  - If last: IDLE.
- Refill is never preempted. A data request arriving mid-refill waits until IDLE.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on each data grant while ic_req_valid=1.
  - Clears on I-side grant or when ic_req_valid=0.
- Best-case latency: request cycle N → mem_req_valid N+1 → response earliest N+2.
- mem_rsp_valid in IDLE/REQ states (stray) is ignored.
- Reset mid-operation: all outputs drop immediately; the partial burst is abandoned with no ic_rdata_last. The requester must re-request.

Optional Feature:
- Macro: ARB_CRITICAL_WORD_FIRST_EN.
- Defined: word_ptr initialises to ic_req_addr word offset, so the missing word returns first and the burst wraps through the line.
- Undefined: word_ptr initialises to 0. ic_req_addr offset bits are ignored and the burst is always in ascending order.

Decomposition:
- riscv_pkg gains:
  - arb_state_e enum (IDLE, D_REQ, D_WAIT, IC_REQ, IC_WAIT)
  - ARB_LINE_WORDS = ICACHE_LINE_SIZE/4
  - ARB_STARVE_LIMIT
  - mem_req_t packed struct (we, addr, wdata, be)
- Single module; no sub-module needed.

Test Plan:
- Lone load d_req_addr=0x100; memory returns 0xDEADBEEF → mem_req_addr=0x100 one cycle after accept; d_rsp_valid with 0xDEADBEEF; busy falls next cycle.
- Refill ic_req_addr=0x40, macro off → bus reads 0x40,0x44,0x48,0x4C; ic_rdata_idx 0..3; ic_rdata_last only on 4th beat.
- ic_req_valid held, continuous data requests → four data grants, then I-side granted on 5th arbitration; starve_cnt cleared.
- d_req_valid raised during beat 1 of refill → d_req_ready low until refill done; data granted in the first IDLE cycle after.
- Macro on, ic_req_addr=0x48 → reads 0x48,0x4C,0x40,0x44 with idx 2,3,0,1; last on idx 1.
- rst asserted in IC_WAIT after 2 beats → all outputs 0 that cycle; stray mem_rsp_valid ignored; new load afterwards completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory-bus arbiter (I-cache refill vs. LSU).
package mem_port_arbiter_pkg;

  localparam int ARB_XLEN         = 32;
  localparam int ICACHE_LINE_SIZE = 16;
  localparam int ARB_LINE_WORDS   = ICACHE_LINE_SIZE / 4;
  localparam int ARB_STARVE_LIMIT = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    D_REQ   = 3'd1,
    D_WAIT  = 3'd2,
    IC_REQ  = 3'd3,
    IC_WAIT = 3'd4
  } arb_state_e;

  typedef struct packed {
    logic                  we;
    logic [ARB_XLEN-1:0]   addr;
    logic [ARB_XLEN-1:0]   wdata;
    logic [ARB_XLEN/8-1:0] be;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter between I-cache line refill bursts and LSU word accesses.
// Optional ARB_CRITICAL_WORD_FIRST_EN: refill starts at the missing word and wraps through the line.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN         = ARB_XLEN,
  parameter int LINE_WORDS   = ARB_LINE_WORDS,
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ic_req_valid,
  input  logic [XLEN-1:0]               ic_req_addr,
  output logic                          ic_req_ready,
  output logic                          ic_rdata_valid,
  output logic [XLEN-1:0]               ic_rdata,
  output logic [$clog2(LINE_WORDS)-1:0] ic_rdata_idx,
  output logic                          ic_rdata_last,
  input  logic                          d_req_valid,
  input  logic                          d_req_we,
  input  logic [XLEN-1:0]               d_req_addr,
  input  logic [XLEN-1:0]               d_req_wdata,
  input  logic [XLEN/8-1:0]             d_req_be,
  output logic                          d_req_ready,
  output logic                          d_rsp_valid,
  output logic [XLEN-1:0]               d_rsp_rdata,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic                          mem_req_we,
  output logic [XLEN-1:0]               mem_req_addr,
  output logic [XLEN-1:0]               mem_req_wdata,
  output logic [XLEN/8-1:0]             mem_req_be,
  input  logic                          mem_rsp_valid,
  input  logic [XLEN-1:0]               mem_rsp_rdata,
  output logic                          busy,
  output logic [2:0]                    dbg_state
);

  // mem_req_t is sized by ARB_XLEN, so XLEN is expected to stay at that value.
  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF_W = IDX_W + 2;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  arb_state_e             state;
  mem_req_t               req_q;
  logic [XLEN-OFF_W-1:0]  line_base;
  logic [IDX_W-1:0]       word_ptr;
  logic [IDX_W-1:0]       beat_cnt;
  logic [SC_W-1:0]        starve_cnt;

  logic ic_force;
  logic grant_d;
  logic grant_ic;
  logic last_beat;
  logic in_d_req;
  logic in_ic_req;
  logic unused_addr_bits;

  // Valid/ready: a requester holds valid and its fields stable until ready pulses;
  // the transfer happens in that cycle. The bus side follows the same rule, and each
  // accepted bus request gets exactly one mem_rsp_valid later.
  assign ic_force  = ic_req_valid && (starve_cnt == SC_W'(STARVE_LIMIT));
  assign grant_d   = (state == IDLE) && d_req_valid && !ic_force;
  assign grant_ic  = (state == IDLE) && ic_req_valid && !grant_d;
  assign last_beat = (beat_cnt == IDX_W'(LINE_WORDS - 1));
  assign in_d_req  = (state == D_REQ);
  assign in_ic_req = (state == IC_REQ);

  assign unused_addr_bits = ^ic_req_addr[OFF_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_q      <= '0;
      line_base  <= '0;
      word_ptr   <= '0;
      beat_cnt   <= '0;
      starve_cnt <= '0;
    end else begin
      if (grant_ic || !ic_req_valid) begin
        starve_cnt <= '0;
      end else if (grant_d && (starve_cnt != SC_W'(STARVE_LIMIT))) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (grant_d) begin
            req_q.we    <= d_req_we;
            req_q.addr  <= d_req_addr;
            req_q.wdata <= d_req_wdata;
            req_q.be    <= d_req_be;
            state       <= D_REQ;
          end else if (grant_ic) begin
            line_base <= ic_req_addr[XLEN-1:OFF_W];
`ifdef ARB_CRITICAL_WORD_FIRST_EN
            word_ptr  <= ic_req_addr[OFF_W-1:2];
`else
            word_ptr  <= '0;
`endif
            beat_cnt  <= '0;
            state     <= IC_REQ;
          end
        end
        D_REQ: begin
          if (mem_req_ready) state <= D_WAIT;
        end
        D_WAIT: begin
          if (mem_rsp_valid) state <= IDLE;
        end
        IC_REQ: begin
          if (mem_req_ready) state <= IC_WAIT;
        end
        IC_WAIT: begin
          if (mem_rsp_valid) begin
            if (last_beat) begin
              state <= IDLE;
            end else begin
              word_ptr <= (word_ptr == IDX_W'(LINE_WORDS - 1)) ? '0 : word_ptr + 1'b1;
              beat_cnt <= beat_cnt + 1'b1;
              state    <= IC_REQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Readies are gated by rst so nothing is accepted while reset is asserted.
  always_comb begin
    ic_req_ready   = grant_ic && !rst;
    d_req_ready    = grant_d && !rst;

    mem_req_valid  = in_d_req || in_ic_req;
    mem_req_we     = in_d_req && req_q.we;
    mem_req_addr   = '0;
    mem_req_wdata  = '0;
    mem_req_be     = '0;
    if (in_d_req) begin
      mem_req_addr  = req_q.addr;
      mem_req_wdata = req_q.wdata;
      mem_req_be    = req_q.be;
    end else if (in_ic_req) begin
      mem_req_addr  = {line_base, word_ptr, 2'b00};
      mem_req_be    = '1;
    end

    d_rsp_valid    = (state == D_WAIT) && mem_rsp_valid;
    d_rsp_rdata    = d_rsp_valid ? mem_rsp_rdata : '0;

    ic_rdata_valid = (state == IC_WAIT) && mem_rsp_valid;
    ic_rdata       = ic_rdata_valid ? mem_rsp_rdata : '0;
    ic_rdata_idx   = ic_rdata_valid ? word_ptr : '0;
    ic_rdata_last  = ic_rdata_valid && last_beat;

    busy           = (state != IDLE);
    dbg_state      = state;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: random requesters, memory responder, queue scoreboard.
module tb_mem_port_arbiter;

  localparam int LW    = 4;
  localparam int LIMIT = 4;

  logic        clk;
  logic        rst;
  logic        ic_req_valid;
  logic [31:0] ic_req_addr;
  logic        ic_req_ready;
  logic        ic_rdata_valid;
  logic [31:0] ic_rdata;
  logic [1:0]  ic_rdata_idx;
  logic        ic_rdata_last;
  logic        d_req_valid;
  logic        d_req_we;
  logic [31:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic [3:0]  d_req_be;
  logic        d_req_ready;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_be;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        busy;
  logic [2:0]  dbg_state;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_rdata_valid(ic_rdata_valid), .ic_rdata(ic_rdata), .ic_rdata_idx(ic_rdata_idx),
    .ic_rdata_last(ic_rdata_last),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_be(d_req_be), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .busy(busy), .dbg_state(dbg_state)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_t;

  typedef struct packed {
    logic [1:0]  idx;
    logic        last;
    logic [31:0] data;
  } beat_t;

  bus_t        bus_exp_q[$];
  beat_t       ic_exp_q[$];
  logic [31:0] d_exp_q[$];

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] bus_mem [logic [31:0]];

  int n_tests = 0;
  int n_fail  = 0;
  int ref_starve = 0;
  int ic_beats_seen = 0;
  int bus_hs_cnt = 0;
  int bus_min_dly = 0;
  int stray_req_cnt = 0;
  bit done_prev = 0;
  bit chk_req_next = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] bus_read(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic any_output();
    return |{ic_req_ready, ic_rdata_valid, ic_rdata, ic_rdata_idx, ic_rdata_last,
             d_req_ready, d_rsp_valid, d_rsp_rdata, mem_req_valid, mem_req_we,
             mem_req_addr, mem_req_wdata, mem_req_be, busy, dbg_state};
  endfunction

  // ---------------- memory responder ----------------
  initial begin
    bit          pending;
    int          dly;
    int          stray_done;
    logic [31:0] rsp_data;
    pending = 0; dly = 0; stray_done = 0; rsp_data = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    bus_mem[32'h100] = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        pending = 0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = $urandom();
        if (pending) begin
          if (dly == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = rsp_data;
            pending = 0;
          end else begin
            dly--;
          end
        end else if (stray_done != stray_req_cnt || $urandom_range(0, 7) == 0) begin
          mem_rsp_valid = 1'b1;
          stray_done = stray_req_cnt;
        end
        mem_req_ready = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      if (!rst && mem_req_valid && mem_req_ready) begin
        bus_hs_cnt++;
        if (mem_req_we) begin
          bus_mem[mem_req_addr] = merge(bus_read(mem_req_addr), mem_req_wdata, mem_req_be);
          rsp_data = '0;
        end else begin
          rsp_data = bus_read(mem_req_addr);
        end
        pending = 1;
        dly = bus_min_dly + $urandom_range(0, 2);
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin
    bus_t        eb;
    beat_t       bt;
    logic [31:0] ed;
    logic [31:0] base;
    logic [31:0] a;
    int          start;
    int          w;
    bit          busy_ref;
    bit          exp_d;
    ref_mem[32'h100] = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus_exp_q.delete(); ic_exp_q.delete(); d_exp_q.delete();
        ref_starve = 0; done_prev = 0; chk_req_next = 0;
      end else begin
        busy_ref = (d_exp_q.size() + ic_exp_q.size()) != 0;

        if (d_rsp_valid) begin
          if (d_exp_q.size() == 0) check("d_rsp_unexpected", 1, 0);
          else begin
            ed = d_exp_q.pop_front();
            check("d_rsp_rdata", d_rsp_rdata, ed);
          end
        end
        if (ic_rdata_valid) begin
          ic_beats_seen++;
          if (ic_exp_q.size() == 0) check("ic_rdata_unexpected", 1, 0);
          else begin
            bt = ic_exp_q.pop_front();
            check("ic_beat_idx_last_data", {ic_rdata_idx, ic_rdata_last, ic_rdata}, bt);
          end
        end

        if (mem_req_valid && mem_req_ready) begin
          if (bus_exp_q.size() == 0) check("bus_req_unexpected", 1, 0);
          else begin
            eb = bus_exp_q.pop_front();
            check("bus_we", mem_req_we, eb.we);
            check("bus_addr", mem_req_addr, eb.addr);
            check("bus_be", mem_req_be, eb.be);
            if (eb.we) check("bus_wdata", mem_req_wdata, eb.wdata);
          end
        end

        if (chk_req_next) check("mem_req_valid_after_grant", mem_req_valid, 1);
        if (done_prev) begin
          check("busy_after_done", busy, 0);
          if (d_req_valid || ic_req_valid) check("grant_first_idle", d_req_ready || ic_req_ready, 1);
        end

        if (d_req_ready || ic_req_ready) begin
          check("grant_while_outstanding", busy_ref, 0);
          exp_d = d_req_valid && !(ic_req_valid && ref_starve == LIMIT);
          check("arb_winner", {d_req_ready, ic_req_ready}, {exp_d, !exp_d && ic_req_valid});
        end

        if (d_req_ready) begin
          bus_exp_q.push_back('{d_req_we, d_req_addr, d_req_wdata, d_req_be});
          if (d_req_we) begin
            d_exp_q.push_back(32'h0);
            ref_mem[d_req_addr] = merge(ref_read(d_req_addr), d_req_wdata, d_req_be);
          end else begin
            d_exp_q.push_back(ref_read(d_req_addr));
          end
        end
        if (ic_req_ready) begin
          base = ic_req_addr & ~32'(LW * 4 - 1);
`ifdef ARB_CRITICAL_WORD_FIRST_EN
          start = int'(ic_req_addr[3:2]);
`else
          start = 0;
`endif
          for (int b = 0; b < LW; b++) begin
            w = (start + b) % LW;
            a = base + 32'(w * 4);
            bus_exp_q.push_back('{1'b0, a, 32'h0, 4'hF});
            ic_exp_q.push_back('{2'(w), (b == LW - 1), ref_read(a)});
          end
        end

        if (ic_req_ready || !ic_req_valid) ref_starve = 0;
        else if (d_req_ready && ref_starve < LIMIT) ref_starve++;

        chk_req_next = d_req_ready || ic_req_ready;
        done_prev = busy_ref && (d_exp_q.size() + ic_exp_q.size()) == 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be);
    bit got;
    got = 0;
    d_req_valid = 1'b1; d_req_we = we; d_req_addr = addr; d_req_wdata = wdata; d_req_be = be;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (d_req_ready) begin got = 1; break; end
    end
    check("d_req_accept", got, 1);
    @(posedge clk); #1;
    d_req_valid = 1'b0;
  endtask

  task automatic do_ic(input logic [31:0] addr);
    bit got;
    got = 0;
    ic_req_valid = 1'b1; ic_req_addr = addr;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ic_req_ready) begin got = 1; break; end
    end
    check("ic_req_accept", got, 1);
    @(posedge clk); #1;
    ic_req_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 600; i++) begin
      if (ic_exp_q.size() == 0) begin got = 1; break; end
      @(posedge clk); #1;
    end
    check("ic_burst_done", got, 1);
  endtask

  task automatic wait_quiet();
    bit got;
    got = 0;
    for (int i = 0; i < 800; i++) begin
      if (d_exp_q.size() == 0 && ic_exp_q.size() == 0 && bus_exp_q.size() == 0) begin
        got = 1; break;
      end
      @(posedge clk); #1;
    end
    check("quiet_timeout", got, 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int base_beats;
    int hs0;
    bit got;
    rst = 1'b1;
    ic_req_valid = 1'b0; ic_req_addr = '0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = '0; d_req_wdata = '0; d_req_be = '0;
    #1;
    check("reset_outputs_zero", any_output(), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // lone load, memory holds 0xDEADBEEF
    do_d(1'b0, 32'h100, 32'h0, 4'hF);
    wait_quiet();

    // one refill of line 0x40
    do_ic(32'h40);
    wait_quiet();

    // I-side held while data keeps requesting
    fork
      do_ic(32'h80);
      begin
        for (int k = 0; k < 6; k++) do_d(1'b0, 32'h200 + 32'(k * 4), 32'h0, 4'hF);
      end
    join
    wait_quiet();

    // data request raised during refill
    base_beats = ic_beats_seen;
    fork
      do_ic(32'hC4);
      begin
        for (int i = 0; i < 200; i++) begin
          if (ic_beats_seen > base_beats) break;
          @(posedge clk); #1;
        end
        do_d(1'b1, 32'h204, 32'hA5A5_1234, 4'b0101);
      end
    join
    wait_quiet();
    do_d(1'b0, 32'h204, 32'h0, 4'hF);
    wait_quiet();

    // reset during the third refill beat's wait
    bus_min_dly = 3;
    base_beats = ic_beats_seen;
    fork
      do_ic(32'h148);
      begin
        got = 0;
        for (int i = 0; i < 400; i++) begin
          @(negedge clk);
          if (ic_beats_seen >= base_beats + 2) begin got = 1; break; end
        end
        check("rst_test_two_beats", got, 1);
        hs0 = bus_hs_cnt;
        got = 0;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (bus_hs_cnt > hs0) begin got = 1; break; end
        end
        check("rst_test_third_handshake", got, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_mid_burst_outputs_zero", any_output(), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus_min_dly = 0;
        stray_req_cnt++;
        @(negedge clk);
        check("stray_rsp_driven", mem_rsp_valid, 1);
        check("stray_rsp_ignored", {d_rsp_valid, ic_rdata_valid, busy}, 3'b000);
      end
    join
    idle(1);
    do_d(1'b0, 32'h100, 32'h0, 4'hF);
    wait_quiet();

    // random traffic from both requesters
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          idle($urandom_range(0, 6));
          do_ic(32'($urandom_range(0, 31)) << 2);
        end
      end
      begin
        for (int k = 0; k < 100; k++) begin
          logic        we;
          logic [31:0] addr;
          idle($urandom_range(0, 3));
          we = 1'($urandom_range(0, 1));
          addr = 32'($urandom_range(0, 31)) << 2;
          do_d(we, addr, $urandom(), we ? 4'($urandom_range(1, 15)) : 4'hF);
        end
      end
    join
    wait_quiet();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
